// File: rtl/sd_read_sequencer.sv
// Block-read controller for the SD_Sim BRAM. A start request reads `length`
// consecutive words from `base_addr`, absorbs the BRAM read latency through a
// small valid-bit pipe, and streams the words out of a FIFO with backpressure.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_WAIT    | idle after reset, waiting for start
// ST_BUSY    | issuing reads and delivering words until `length` transferred
// ST_SUCCESS | block fully delivered, waiting for next start
// ST_ABORTED | read cancelled, FIFO and in-flight returns discarded
module sd_read_sequencer #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 11,
   parameter int RD_LATENCY = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              mem_ena,
   output logic              mem_wea,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        state,
   output logic              done
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      ST_WAIT    = 3'd0,
      ST_BUSY    = 3'd1,
      ST_SUCCESS = 3'd2,
      ST_ABORTED = 3'd3
   } state_t;

   state_t              state_q, state_d;
   logic                done_q, done_d;
   logic [ADDR_W:0]     len_q, issued_q, delivered_q;
   logic [ADDR_W-1:0]   next_addr_q, last_addr_q;
   logic [RD_LATENCY-1:0] pipe_q, pipe_d;
   logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    fifo_count_q, inflight;
   logic                start_acc, abort_acc, issue, push, pop, room, last_pop;

   assign out_valid = (fifo_count_q != '0);
   assign pop       = out_valid & out_ready;
   assign last_pop  = pop && ((delivered_q + (ADDR_W+1)'(1)) == len_q);
   assign push      = pipe_q[RD_LATENCY-1] & ~abort_acc;

   // count reads still travelling through the BRAM latency
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + CNT_W'(pipe_q[i]);
      end
   end

   // a read may only be issued if its word is guaranteed a FIFO slot
   assign room = ({1'b0, fifo_count_q} + {1'b0, inflight}) < (CNT_W+1)'(FIFO_DEPTH);

   // next-state, issue decision and done pulse
   always_comb begin
      state_d   = state_q;
      done_d    = 1'b0;
      start_acc = 1'b0;
      abort_acc = 1'b0;
      issue     = 1'b0;
      case (state_q)
         ST_BUSY: begin
            if (abort) begin
               state_d   = ST_ABORTED;
               abort_acc = 1'b1;
               done_d    = 1'b1;
            end else begin
               issue = (issued_q < len_q) && room;
               if (last_pop) begin
                  state_d = ST_SUCCESS;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            if (start) begin
               start_acc = 1'b1;
               if (length == '0) begin
                  state_d = ST_SUCCESS;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_BUSY;
               end
            end
         end
      endcase
   end

   // shift in-flight markers; an abort discards everything still in the pipe
   always_comb begin
      pipe_d = '0;
      if (!abort_acc) begin
         pipe_d[0] = issue;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_WAIT;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   // counters, address generation, pipe and FIFO pointers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_q        <= '0;
         issued_q     <= '0;
         delivered_q  <= '0;
         next_addr_q  <= '0;
         last_addr_q  <= '0;
         pipe_q       <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_count_q <= '0;
      end else begin
         pipe_q <= pipe_d;
         if (start_acc) begin
            len_q       <= length;
            issued_q    <= '0;
            delivered_q <= '0;
            next_addr_q <= base_addr;
         end else if (issue) begin
            issued_q    <= issued_q + (ADDR_W+1)'(1);
            next_addr_q <= next_addr_q + ADDR_W'(1);
            last_addr_q <= next_addr_q;
         end
         if (abort_acc) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
         end else begin
            if (push) begin
               wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
               delivered_q <= delivered_q + (ADDR_W+1)'(1);
            end
            fifo_count_q <= fifo_count_q + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // FIFO storage; contents are don't-care until the count says otherwise
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= mem_dout;
      end
   end

   assign mem_ena  = issue;
   assign mem_wea  = 1'b0;
   assign mem_addr = issue ? next_addr_q : last_addr_q;
   assign out_data = out_valid ? fifo_mem[rd_ptr_q] : '0;
   assign state    = state_q;
   assign done     = done_q;

endmodule

// File: tb/tb_sd_read_sequencer.sv
// Bench for sd_read_sequencer: BRAM model, expected-word and expected-address
// queues filled at start, and a negedge monitor that checks every transfer.
module tb_sd_read_sequencer;
   localparam int ADDR_W     = 8;
   localparam int DATA_W     = 11;
   localparam int RD_LATENCY = 1;
   localparam int FIFO_DEPTH = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   length = '0;
   logic              mem_ena, mem_wea;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_dout = '0;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [2:0]        state;
   logic              done;

   logic [DATA_W-1:0] bram [256];
   logic [DATA_W-1:0] exp_data_q [$];
   logic [ADDR_W-1:0] exp_addr_q [$];
   int n_cmp = 0;
   int n_err = 0;
   int xfer_cnt = 0;
   int ena_total = 0;

   sd_read_sequencer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .base_addr(base_addr), .length(length),
      .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .state(state), .done(done)
   );

   always #5 clk = ~clk;

   // synchronous-read BRAM, one cycle latency
   always @(posedge clk) begin
      if (mem_ena) mem_dout <= bram[mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_unexpected(input string name, input logic [31:0] act);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got %0h expected nothing (t=%0t)", name, act, $time);
   endtask

   // monitor: reads against expected addresses, transfers against expected words
   initial begin
      logic              hold_v;
      logic [DATA_W-1:0] hold_d;
      hold_v = 1'b0;
      hold_d = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            hold_v = 1'b0;
         end else begin
            if (mem_ena) begin
               ena_total++;
               check("mem_wea", 32'(mem_wea), 32'd0);
               if (exp_addr_q.size() == 0) fail_unexpected("unexpected_read", 32'(mem_addr));
               else check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            end
            if (hold_v && out_valid) check("stall_hold", 32'(out_data), 32'(hold_d));
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            if (out_valid && out_ready) begin
               xfer_cnt++;
               if (exp_data_q.size() == 0) fail_unexpected("unexpected_word", 32'(out_data));
               else check("out_data", 32'(out_data), 32'(exp_data_q.pop_front()));
            end
         end
      end
   end

   // one block read; rmode 0 = ready high, 1 = random ready, 2 = 10-cycle stall after first valid
   task automatic run_txn(input int base, input int len, input int abort_at, input int rmode,
                          input bit extra_start, output int done_cyc, output int fv, output int fe);
      int cyc;
      bit exp_abort;
      bit stall_checked;
      int ena_snap;
      for (int i = 0; i < len; i++) begin
         exp_addr_q.push_back(8'(base + i));
         exp_data_q.push_back(bram[8'(base + i)]);
      end
      xfer_cnt = 0;
      ena_snap = ena_total;
      exp_abort = 1'b0;
      stall_checked = 1'b0;
      done_cyc = -1;
      fv = -1;
      fe = -1;
      base_addr = 8'(base);
      length = 9'(len);
      start = 1'b1;
      if (rmode == 1) out_ready = ($urandom % 4) != 0;
      else out_ready = (rmode == 0);
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (cyc < 3000) begin
         @(negedge clk);
         if (out_valid && fv < 0) fv = cyc;
         if (mem_ena && fe < 0) fe = cyc;
         if (done) begin
            done_cyc = cyc;
            break;
         end
         @(posedge clk); #1;
         cyc++;
         start = 1'b0;
         if (abort) begin
            abort = 1'b0;
            exp_addr_q.delete();
            exp_data_q.delete();
         end
         if (cyc == abort_at && xfer_cnt < len) begin
            abort = 1'b1;
            exp_abort = 1'b1;
         end
         if (extra_start && cyc == 2) begin
            start = 1'b1;
            base_addr = 8'($urandom);
            length = 9'($urandom_range(1, 20));
         end
         if (rmode == 1) out_ready = ($urandom % 4) != 0;
         else if (rmode == 2 && fv >= 0 && cyc >= fv + 10) begin
            if (!stall_checked) begin
               check("stall_reads", 32'(ena_total - ena_snap), 32'(FIFO_DEPTH));
               stall_checked = 1'b1;
            end
            out_ready = 1'b1;
         end
      end
      if (done_cyc < 0) fail_unexpected("done_timeout", 32'(cyc));
      check("end_state", 32'(state), exp_abort ? 32'd3 : 32'd2);
      check("end_valid", 32'(out_valid), 32'd0);
      check("words_left", 32'(exp_data_q.size()), 32'd0);
      if (exp_abort) check("abort_done_cycle", 32'(done_cyc), 32'(abort_at + 1));
      else if (rmode == 0) check("done_cycle", 32'(done_cyc), (len == 0) ? 32'd1 : 32'(len + 3));
      if (!exp_abort) check("xfer_count", 32'(xfer_cnt), 32'(len));
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      check("done_width", 32'(done), 32'd0);
      check("idle_ena", 32'(mem_ena), 32'd0);
   endtask

   initial begin
      int dc, fv, fe;
      for (int i = 0; i < 256; i++) bram[i] = DATA_W'($urandom);

      // reset values
      @(negedge clk);
      check("rst_state", 32'(state), 32'd0);
      check("rst_ena", 32'(mem_ena), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // basic 4-word read with exact timing
      run_txn(32'h10, 4, -1, 0, 1'b0, dc, fv, fe);
      check("t1_first_ena", 32'(fe), 32'd1);
      check("t1_first_valid", 32'(fv), 32'd3);

      // abort outside BUSY is ignored
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("idle_abort_state", 32'(state), 32'd2);
      check("idle_abort_done", 32'(done), 32'd0);

      // address wrap
      run_txn(32'hFE, 4, -1, 0, 1'b0, dc, fv, fe);
      // backpressure stall
      run_txn(32'h33, 8, -1, 2, 1'b0, dc, fv, fe);
      // full block
      run_txn(0, 256, -1, 0, 1'b0, dc, fv, fe);
      // abort in 3rd BUSY cycle, then fresh read
      run_txn(32'h80, 10, 3, 0, 1'b0, dc, fv, fe);
      run_txn(32'h21, 2, -1, 0, 1'b0, dc, fv, fe);
      // zero length
      run_txn(32'h55, 0, -1, 0, 1'b0, dc, fv, fe);
      check("len0_no_ena", 32'(fe), 32'hFFFF_FFFF);

      // randomized reads
      for (int t = 0; t < 25; t++) begin
         int b, l, a, m;
         b = int'($urandom % 256);
         l = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 48));
         a = (($urandom % 3) == 0) ? int'($urandom_range(2, 30)) : -1;
         m = int'($urandom % 2);
         run_txn(b, l, a, m, bit'($urandom % 2), dc, fv, fe);
      end

      // asynchronous reset in the middle of a read
      for (int i = 0; i < 20; i++) begin
         exp_addr_q.push_back(8'(32'h40 + i));
         exp_data_q.push_back(bram[8'(32'h40 + i)]);
      end
      out_ready = 1'b1;
      base_addr = 8'h40;
      length = 9'd20;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("arst_state", 32'(state), 32'd0);
      check("arst_ena", 32'(mem_ena), 32'd0);
      check("arst_addr", 32'(mem_addr), 32'd0);
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_data", 32'(out_data), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      exp_addr_q.delete();
      exp_data_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      run_txn(32'hC7, 5, -1, 0, 1'b0, dc, fv, fe);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
